// File: rtl/rv_bits_remove_pipe.sv
// rv_bits_remove_pipe: two-stage valid/ready pipeline that removes a runtime
// field [pos, pos+size) from an N-bit word, shifts the upper bits down and
// fills the freed MSBs with zeros (FILL_MODE=0) or the result's top valid bit
// (FILL_MODE=1). Out-of-range requests are clamped and flagged on out_err.
// Optional macro RV_BITS_REMOVE_CAPTURE_EN adds out_field, the removed field
// right-aligned, carried with the same latency and stall behaviour.
module rv_bits_remove_pipe #(
   parameter int N         = 32,
   parameter int TAG_W     = 4,
   parameter int FILL_MODE = 0,
   parameter int PW        = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic [PW-1:0]    in_pos,
   input  logic [PW-1:0]    in_size,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic [PW-1:0]    out_len,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag
`ifdef RV_BITS_REMOVE_CAPTURE_EN
   ,
   output logic [N-1:0]     out_field
`endif
);

   localparam logic [PW-1:0] N_PW   = PW'(N);
   localparam logic [PW:0]   N_PW1  = (PW + 1)'(N);
   localparam logic [PW-1:0] ONE_PW = PW'(1);
   localparam logic [N-1:0]  ONES   = {N{1'b1}};
   localparam logic [N-1:0]  BIT0   = {{(N-1){1'b0}}, 1'b1};

   // Stage-1 combinational clamp/split results
   logic [PW-1:0] pos_c_s, room_s, size_eff_s, len_s;
   logic [PW:0]   sum_s, shamt_s;
   logic          err_s;
   logic [N-1:0]  low_s, high_s;
   // Handshake
   logic          s1_adv_s, s2_adv_s;
   // Stage-1 registers
   logic             s1_valid_q, s1_valid_d;
   logic [N-1:0]     s1_low_q, s1_low_d, s1_high_q, s1_high_d;
   logic [PW-1:0]    s1_pos_q, s1_pos_d, s1_len_q, s1_len_d;
   logic             s1_err_q, s1_err_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
   // Stage-2 merge and registers (these drive the out_* ports)
   logic [N-1:0]     merged_s, hi_mask_s, filled_s;
   logic             fill_bit_s;
   logic             s2_valid_q, s2_valid_d;
   logic [N-1:0]     s2_data_q, s2_data_d;
   logic [PW-1:0]    s2_len_q, s2_len_d;
   logic             s2_err_q, s2_err_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
`ifdef RV_BITS_REMOVE_CAPTURE_EN
   logic [N-1:0]     field_s, s1_field_q, s1_field_d, s2_field_q, s2_field_d;
`endif

   // Stage 1: clamp position/size, flag range errors, split word around field
   always_comb begin
      pos_c_s    = (in_pos > N_PW) ? N_PW : in_pos;
      room_s     = N_PW - pos_c_s;
      size_eff_s = (in_size > room_s) ? room_s : in_size;
      sum_s      = {1'b0, in_pos} + {1'b0, in_size};
      err_s      = (in_pos > N_PW) || (sum_s > N_PW1);
      shamt_s    = {1'b0, pos_c_s} + {1'b0, size_eff_s};
      low_s      = in_data & ~(ONES << pos_c_s);
      high_s     = in_data >> shamt_s;
      len_s      = N_PW - size_eff_s;
`ifdef RV_BITS_REMOVE_CAPTURE_EN
      field_s    = (in_data >> pos_c_s) & ~(ONES << size_eff_s);
`endif
   end

   // Handshake: a stage advances when its successor can take its content
   always_comb begin
      s2_adv_s = !s2_valid_q || out_ready;
      s1_adv_s = !s1_valid_q || s2_adv_s;
      in_ready = s1_adv_s;
   end

   // Stage-1 next state: load a new request when advancing, otherwise hold
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_low_d   = s1_low_q;
      s1_high_d  = s1_high_q;
      s1_pos_d   = s1_pos_q;
      s1_len_d   = s1_len_q;
      s1_err_d   = s1_err_q;
      s1_tag_d   = s1_tag_q;
`ifdef RV_BITS_REMOVE_CAPTURE_EN
      s1_field_d = s1_field_q;
`endif
      if (s1_adv_s) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_low_d   = low_s;
            s1_high_d  = high_s;
            s1_pos_d   = pos_c_s;
            s1_len_d   = len_s;
            s1_err_d   = err_s;
            s1_tag_d   = in_tag;
`ifdef RV_BITS_REMOVE_CAPTURE_EN
            s1_field_d = field_s;
`endif
         end else begin
            s1_tag_d   = s1_tag_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // Stage 2 merge: close the gap, then apply the optional sign-style fill
   always_comb begin
      merged_s   = s1_low_q | (s1_high_q << s1_pos_q);
      hi_mask_s  = ONES << s1_len_q;
      fill_bit_s = |(merged_s & (BIT0 << (s1_len_q - ONE_PW)));
      if ((FILL_MODE == 1) && (s1_len_q != '0) && (s1_len_q < N_PW)) begin
         filled_s = fill_bit_s ? (merged_s | hi_mask_s) : (merged_s & ~hi_mask_s);
      end else begin
         filled_s = merged_s;
      end
   end

   // Stage-2 next state: take stage 1 when advancing, otherwise hold outputs
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_len_d   = s2_len_q;
      s2_err_d   = s2_err_q;
      s2_tag_d   = s2_tag_q;
`ifdef RV_BITS_REMOVE_CAPTURE_EN
      s2_field_d = s2_field_q;
`endif
      if (s2_adv_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d  = filled_s;
            s2_len_d   = s1_len_q;
            s2_err_d   = s1_err_q;
            s2_tag_d   = s1_tag_q;
`ifdef RV_BITS_REMOVE_CAPTURE_EN
            s2_field_d = s1_field_q;
`endif
         end else begin
            s2_tag_d   = s2_tag_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Pipeline registers; reset drops everything in flight and zeroes outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_low_q   <= '0;
         s1_high_q  <= '0;
         s1_pos_q   <= '0;
         s1_len_q   <= '0;
         s1_err_q   <= 1'b0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_len_q   <= '0;
         s2_err_q   <= 1'b0;
         s2_tag_q   <= '0;
`ifdef RV_BITS_REMOVE_CAPTURE_EN
         s1_field_q <= '0;
         s2_field_q <= '0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_low_q   <= s1_low_d;
         s1_high_q  <= s1_high_d;
         s1_pos_q   <= s1_pos_d;
         s1_len_q   <= s1_len_d;
         s1_err_q   <= s1_err_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_len_q   <= s2_len_d;
         s2_err_q   <= s2_err_d;
         s2_tag_q   <= s2_tag_d;
`ifdef RV_BITS_REMOVE_CAPTURE_EN
         s1_field_q <= s1_field_d;
         s2_field_q <= s2_field_d;
`endif
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_len   = s2_len_q;
   assign out_err   = s2_err_q;
   assign out_tag   = s2_tag_q;
`ifdef RV_BITS_REMOVE_CAPTURE_EN
   assign out_field = s2_field_q;
`endif

endmodule

// File: tb/tb_rv_bits_remove_pipe.sv
// Bench for rv_bits_remove_pipe at N=8: two instances (FILL_MODE 0 and 1)
// share all inputs. Directed vector table, stall stream, async reset and a
// random phase checked by a bit-loop reference model and scoreboard.
module tb_rv_bits_remove_pipe;
   localparam int N = 8;
   localparam int PW = 4;
   localparam int TW = 4;

   logic clk = 1'b0, reset = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b1;
   logic [N-1:0] in_data = '0;
   logic [PW-1:0] in_pos = '0, in_size = '0;
   logic [TW-1:0] in_tag = '0;
   logic in_ready, out_valid, out_err, in_ready1, out_valid1, out_err1;
   logic [N-1:0] out_data, out_data1;
   logic [PW-1:0] out_len, out_len1;
   logic [TW-1:0] out_tag, out_tag1;
`ifdef RV_BITS_REMOVE_CAPTURE_EN
   logic [N-1:0] out_field, out_field1;
`endif

   rv_bits_remove_pipe #(.N(N), .TAG_W(TW), .FILL_MODE(0)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_pos(in_pos), .in_size(in_size), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_len(out_len), .out_err(out_err), .out_tag(out_tag)
`ifdef RV_BITS_REMOVE_CAPTURE_EN
      , .out_field(out_field)
`endif
   );

   rv_bits_remove_pipe #(.N(N), .TAG_W(TW), .FILL_MODE(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_pos(in_pos), .in_size(in_size), .in_tag(in_tag),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .out_len(out_len1), .out_err(out_err1), .out_tag(out_tag1)
`ifdef RV_BITS_REMOVE_CAPTURE_EN
      , .out_field(out_field1)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0, pops = 0, unstall_cyc = 0;
   bit mon_en = 1'b0, stall_prev = 1'b0;

   typedef struct {
      logic [7:0] d; logic [3:0] pos; logic [3:0] size; logic [3:0] tag;
      logic [7:0] e0; logic [7:0] e1; logic [3:0] len; logic err; logic [7:0] fld;
   } vec_t;
   typedef struct {
      logic [7:0] d0; logic [7:0] d1; logic [7:0] fld; logic [3:0] len; logic err; logic [3:0] tag;
   } exp_t;

   exp_t q[$];
   int pop_cyc[$];
   logic [7:0] h_data; logic [3:0] h_len, h_tag; logic h_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: gather surviving bits one at a time, then apply the fill
   function automatic exp_t model(input logic [7:0] d, input logic [3:0] pos,
                                  input logic [3:0] size, input logic [3:0] tag);
      exp_t e;
      int pc, se, j;
      pc = (int'(pos) > N) ? N : int'(pos);
      se = (int'(size) > N - pc) ? N - pc : int'(size);
      e.err = (int'(pos) + int'(size)) > N;
      e.d0 = 8'h00; e.fld = 8'h00; j = 0;
      for (int i = 0; i < N; i++) begin
         if (i >= pc && i < pc + se) e.fld[i - pc] = d[i];
         else begin e.d0[j] = d[i]; j++; end
      end
      e.len = 4'(N - se);
      e.d1 = e.d0;
      if ((N - se) > 0 && (N - se) < N)
         for (int i = N - se; i < N; i++) e.d1[i] = e.d0[N - se - 1];
      e.tag = tag;
      return e;
   endfunction

   always @(posedge clk) cyc++;

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (mon_en) begin
         if (stall_prev) begin
            chk("hold_data", out_data, h_data);
            chk("hold_len", out_len, h_len);
            chk("hold_err", out_err, h_err);
            chk("hold_tag", out_tag, h_tag);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_data0", out_data, e.d0);
               chk("sb_data1", out_data1, e.d1);
               chk("sb_len", out_len, e.len);
               chk("sb_err", out_err, e.err);
               chk("sb_tag", out_tag, e.tag);
               chk("sb_valid1", out_valid1, 1'b1);
`ifdef RV_BITS_REMOVE_CAPTURE_EN
               chk("sb_field", out_field, e.fld);
`endif
               pops++;
               pop_cyc.push_back(cyc);
            end
         end
         stall_prev = out_valid && !out_ready;
         h_data = out_data; h_len = out_len; h_err = out_err; h_tag = out_tag;
         if (in_valid && in_ready) q.push_back(model(in_data, in_pos, in_size, in_tag));
      end
   end

   vec_t vt[8];

   initial begin
      vt[0] = '{8'hB6, 4'd2, 4'd3, 4'd5, 8'h16, 8'hF6, 4'd5, 1'b0, 8'h05};
      vt[1] = '{8'hB6, 4'd6, 4'd4, 4'd1, 8'h36, 8'hF6, 4'd6, 1'b1, 8'h02};
      vt[2] = '{8'hB6, 4'd8, 4'd0, 4'd2, 8'hB6, 8'hB6, 4'd8, 1'b0, 8'h00};
      vt[3] = '{8'hB6, 4'd0, 4'd8, 4'd3, 8'h00, 8'h00, 4'd0, 1'b0, 8'hB6};
      vt[4] = '{8'hA5, 4'd9, 4'd1, 4'd4, 8'hA5, 8'hA5, 4'd8, 1'b1, 8'h00};
      vt[5] = '{8'h3C, 4'd0, 4'd2, 4'd6, 8'h0F, 8'h0F, 4'd6, 1'b0, 8'h00};
      vt[6] = '{8'h81, 4'd1, 4'd6, 4'd7, 8'h03, 8'hFF, 4'd2, 1'b0, 8'h00};
      vt[7] = '{8'hFF, 4'd4, 4'd5, 4'd8, 8'h0F, 8'hFF, 4'd4, 1'b1, 8'h0F};

      // Reset, released between edges
      #12 reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_len", out_len, 4'd0);
      chk("rst_out_tag", out_tag, 4'd0);

      // Directed vector table, one request at a time
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_data = vt[k].d; in_pos = vt[k].pos;
         in_size = vt[k].size; in_tag = vt[k].tag; out_ready = 1'b1;
         @(negedge clk);
         chk("vec_in_ready", in_ready, 1'b1);
         @(posedge clk); #1 in_valid = 1'b0;
         @(negedge clk);
         chk("vec_latency", out_valid, 1'b0);
         @(posedge clk);
         @(negedge clk);
         chk("vec_valid", out_valid, 1'b1);
         chk("vec_data0", out_data, vt[k].e0);
         chk("vec_data1", out_data1, vt[k].e1);
         chk("vec_len", out_len, vt[k].len);
         chk("vec_err", out_err, vt[k].err);
         chk("vec_tag", out_tag, vt[k].tag);
`ifdef RV_BITS_REMOVE_CAPTURE_EN
         chk("vec_field", out_field, vt[k].fld);
`endif
      end
      @(posedge clk); #1;

      // Back-to-back stream of 8 with a 5-cycle output stall mid-stream
      mon_en = 1'b1; pops = 0;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               int g;
               @(posedge clk); #1;
               in_valid = 1'b1; in_data = 8'(8'h5A + 37 * k); in_pos = 4'(k % 7);
               in_size = 4'((k * 3) % 9); in_tag = 4'(k);
               @(negedge clk);
               g = 0;
               while (!in_ready && g < 40) begin @(negedge clk); g++; end
               if (g >= 40) chk("stream_accept_timeout", 32'd1, 32'd0);
            end
            @(posedge clk); #1 in_valid = 1'b0;
         end
         begin
            int g;
            g = 0;
            while (pops < 3 && g < 50) begin @(posedge clk); g++; end
            #1 out_ready = 1'b0;
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk("stall_in_ready_low", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            @(posedge clk); #1 out_ready = 1'b1;
            unstall_cyc = cyc;
         end
      join
      for (int g = 0; g < 40 && pops < 8; g++) @(posedge clk);
      chk("stream_count", pops, 8);
      for (int i = 1; i < pop_cyc.size(); i++)
         if (pop_cyc[i-1] >= unstall_cyc) chk("throughput", pop_cyc[i] - pop_cyc[i-1], 1);

      // Asynchronous reset with both stages full
      mon_en = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC3; in_pos = 4'd1; in_size = 4'd2; in_tag = 4'd9;
      @(posedge clk); #1;
      in_data = 8'h7E; in_tag = 4'd10;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", out_valid, 1'b1);
      chk("pre_rst_in_ready", in_ready, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_data", out_data, 8'h00);
      chk("arst_len", out_len, 4'd0);
      chk("arst_err", out_err, 1'b0);
      chk("arst_tag", out_tag, 4'd0);
`ifdef RV_BITS_REMOVE_CAPTURE_EN
      chk("arst_field", out_field, 8'h00);
`endif
      @(posedge clk); #3 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_stale_out", out_valid, 1'b0);
      end

      // Random traffic against the reference model
      q.delete(); pops = 0; stall_prev = 1'b0; mon_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = 8'($urandom);
         in_pos = 4'($urandom_range(0, N + 2));
         in_size = 4'($urandom_range(0, N + 2));
         in_tag = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      for (int g = 0; g < 20 && q.size() != 0; g++) @(posedge clk);
      @(negedge clk);
      chk("random_drained", q.size(), 0);
      chk("random_some_results", (pops > 50) ? 1 : 0, 1);
      mon_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
